mult_div_unit: RTL

- Multi-cycle multiply/divide unit in the EX stage of the pipelined MIPS core.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers.
- HI and LO feed the downstream EX result-select mux (MFHI/MFLO path).
- busy drives the hazard unit, which stalls the ID stage on any later MD-class instruction while an operation is in flight.

---
 rtl/mult_div_unit_pkg.sv | 22 ++
 rtl/mult_div_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared md_op encodings and sizing for the multiply/divide unit and the decoder.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NOP6  = 3'd6,
        MD_NOP7  = 3'd7
    } md_op_e;

    localparam int CNT_W = 16;

    // Only the four arithmetic ops (encodings 0..3) may launch a multi-cycle operation.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding HI/LO. Results are computed at the start
// edge into pending registers and committed to HI/LO when the down-counter expires.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        we,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_skip_q, pend_skip_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, div_b, q_mag, r_mag, q_res, r_res;
    logic        is_signed_div;

    // Signed division is done on magnitudes so that truncation toward zero and the
    // 0x80000000 / -1 case fall out of unsigned arithmetic without special handling.
    always_comb begin
        prod_s        = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u        = {32'd0, A} * {32'd0, B};
        is_signed_div = (md_op == MD_DIV);
        a_mag         = (is_signed_div && A[31]) ? (32'd0 - A) : A;
        b_mag         = (is_signed_div && B[31]) ? (32'd0 - B) : B;
        div_b         = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag         = a_mag / div_b;
        r_mag         = a_mag % div_b;
        q_res         = (is_signed_div && (A[31] ^ B[31])) ? (32'd0 - q_mag) : q_mag;
        r_res         = (is_signed_div && A[31]) ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        count_d     = count_q;
        busy_d      = busy_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_skip_d = pend_skip_q;

        if (busy_q) begin
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                if (!pend_skip_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end else if (start) begin
            if (is_arith_op(md_op)) begin
                busy_d      = 1'b1;
                pend_skip_d = 1'b0;
                case (md_op_e'(md_op))
                    MD_MULT: begin
                        pend_hi_d = prod_s[63:32];
                        pend_lo_d = prod_s[31:0];
                        count_d   = CNT_W'(MULT_CYCLES);
                    end
                    MD_MULTU: begin
                        pend_hi_d = prod_u[63:32];
                        pend_lo_d = prod_u[31:0];
                        count_d   = CNT_W'(MULT_CYCLES);
                    end
                    default: begin
                        pend_hi_d   = r_res;
                        pend_lo_d   = q_res;
                        pend_skip_d = (B == 32'd0);
                        count_d     = CNT_W'(DIV_CYCLES);
                    end
                endcase
            end
        end else if (we) begin
            if (md_op == MD_MTHI) begin
                hi_d = A;
            end else if (md_op == MD_MTLO) begin
                lo_d = A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            busy_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            pend_hi_q   <= '0;
            pend_lo_q   <= '0;
            pend_skip_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            busy_q      <= busy_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_skip_q <= pend_skip_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
